rr_timeout_arbiter: RTL and testbench

Round-robin bus arbiter with an acknowledge watchdog and an optional locked-transfer extension. It shares one bus between `N_MASTERS` requesters and replaces fixed-priority selection with a rotating pointer, so every requester is served fairly. A watchdog withdraws any grant whose slave never acknowledges and reports the offending master. It sits between the masters' request lines and the bus multiplexer select.

---
 rtl/rr_timeout_arbiter_pkg.sv | 25 ++
 rtl/rr_timeout_arbiter_picker.sv | 40 ++++
 rtl/rr_timeout_arbiter.sv | 113 +++++++++++
 tb/tb_rr_timeout_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rr_timeout_arbiter_pkg.sv
// Shared arbitration types: master count, request/grant vectors and FSM state.
package arbitration;

    localparam int unsigned N_MASTERS = 4;

    typedef logic [N_MASTERS-1:0]         arb_vector;
    typedef logic [$clog2(N_MASTERS)-1:0] master_idx_t;

    localparam arb_vector NO_GRANT   = '0;
    localparam arb_vector NO_REQUEST = '0;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_t;

    // (idx + 1) mod N_MASTERS, safe for non-power-of-two master counts.
    function automatic master_idx_t next_idx(input master_idx_t idx);
        if (int'(idx) == N_MASTERS - 1) begin
            return '0;
        end
        return master_idx_t'(int'(idx) + 1);
    endfunction

endpackage

// File: rtl/rr_timeout_arbiter_picker.sv
// Combinational round-robin picker: first request at or after rr_ptr wins.
module rr_priority_picker
    import arbitration::*;
(
    input  logic [N_MASTERS-1:0] bus_req,
    input  master_idx_t          rr_ptr,
    output logic [N_MASTERS-1:0] winner,
    output master_idx_t          winner_idx,
    output logic                 winner_valid
);

    logic [2*N_MASTERS-1:0] doubled;
    logic [2*N_MASTERS-1:0] rotated;
    int unsigned            first;
    int unsigned            sum;

    always_comb begin
        doubled      = {bus_req, bus_req};
        // Bit i of the rotated window is request (rr_ptr + i) mod N_MASTERS.
        rotated      = doubled >> rr_ptr;
        first        = 0;
        winner_valid = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first        = i;
                winner_valid = 1'b1;
            end
        end
        sum = int'(rr_ptr) + first;
        if (sum >= N_MASTERS) begin
            sum = sum - N_MASTERS;
        end
        winner_idx = master_idx_t'(sum);
        winner     = '0;
        if (winner_valid) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin bus arbiter with ack watchdog and locked-transfer extension.
module rr_timeout_arbiter
    import arbitration::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  arb_vector   bus_req,
    input  logic        bus_ack,
    input  logic        bus_lock,
    output arb_vector   bus_grant,
    output logic        timeout_err,
    output master_idx_t err_master
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    arb_vector        grant_q, grant_d;
    master_idx_t      grant_idx_q, grant_idx_d;
    master_idx_t      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    master_idx_t      err_master_q, err_master_d;

    arb_vector   winner;
    master_idx_t winner_idx;
    logic        winner_valid;

    rr_priority_picker u_picker (
        .bus_req      (bus_req),
        .rr_ptr       (rr_ptr_q),
        .winner       (winner),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        err_master_d = err_master_q;

        unique case (state_q)
            IDLE: begin
                if (winner_valid) begin
                    state_d     = GRANT;
                    grant_d     = winner;
                    grant_idx_d = winner_idx;
                    rr_ptr_d    = next_idx(winner_idx);
                    cnt_d       = '0;
                end
            end
            GRANT: begin
                if (bus_ack) begin
                    cnt_d = '0;
                    if (bus_lock && bus_req[grant_idx_q]) begin
                        // Locked transfer: same master keeps the bus, pointer untouched.
                    end else if (winner_valid) begin
                        grant_d     = winner;
                        grant_idx_d = winner_idx;
                        rr_ptr_d    = next_idx(winner_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = NO_GRANT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    grant_d      = NO_GRANT;
                    cnt_d        = '0;
                    timeout_d    = 1'b1;
                    err_master_d = grant_idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = NO_GRANT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= NO_GRANT;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            err_master_q <= err_master_d;
        end
    end

    assign bus_grant   = grant_q;
    assign timeout_err = timeout_q;
    assign err_master  = err_master_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Bench for rr_timeout_arbiter: directed plan steps then random traffic vs. a reference model.
module tb_rr_timeout_arbiter;
    import arbitration::*;

    localparam int T = 4;
    localparam int N = N_MASTERS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    arb_vector   bus_req = '0;
    logic        bus_ack = 1'b0;
    logic        bus_lock = 1'b0;
    arb_vector   bus_grant;
    logic        timeout_err;
    master_idx_t err_master;

    rr_timeout_arbiter #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .bus_lock    (bus_lock),
        .bus_grant   (bus_grant),
        .timeout_err (timeout_err),
        .err_master  (err_master)
    );

    always #5 clk = ~clk;

    // Reference model: owner (-1 = bus free), cycles the owner has held the bus, pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_terr  = 0;
    int m_emst  = 0;

    int vectors    = 0;
    int miscompares = 0;

    function automatic void model_pick(input arb_vector req);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req[k]) begin
                m_owner = k;
                m_ptr   = (k + 1) % N;
                m_held  = 1;
                return;
            end
        end
    endfunction

    function automatic void model_step(input arb_vector req, input logic ack, input logic lock,
                                       input logic rst);
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_terr = 0; m_emst = 0;
            return;
        end
        m_terr = 0;
        if (m_owner < 0) begin
            if (req != 0) model_pick(req);
        end else if (ack) begin
            if (lock && req[m_owner]) begin
                m_held = 1;
            end else if (req != 0) begin
                model_pick(req);
            end else begin
                m_owner = -1;
                m_held  = 0;
            end
        end else if (m_held == T) begin
            m_terr  = 1;
            m_emst  = m_owner;
            m_owner = -1;
            m_held  = 0;
        end else begin
            m_held++;
        end
    endfunction

    task automatic step(input arb_vector req, input logic ack, input logic lock, input logic rst,
                        input string tag);
        arb_vector   exp_grant;
        logic        exp_terr;
        master_idx_t exp_emst;
        @(negedge clk);
        bus_req  = req;
        bus_ack  = ack;
        bus_lock = lock;
        reset    = rst;
        model_step(req, ack, lock, rst);
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        exp_terr = (m_terr != 0);
        exp_emst = master_idx_t'(m_emst);
        @(posedge clk);
        #1;
        vectors++;
        assert (bus_grant === exp_grant) else begin
            miscompares++;
            $error("FAIL %s bus_grant: got %b expected %b", tag, bus_grant, exp_grant);
        end
        vectors++;
        assert (timeout_err === exp_terr) else begin
            miscompares++;
            $error("FAIL %s timeout_err: got %b expected %b", tag, timeout_err, exp_terr);
        end
        vectors++;
        assert (err_master === exp_emst) else begin
            miscompares++;
            $error("FAIL %s err_master: got %0d expected %0d", tag, err_master, exp_emst);
        end
    endtask

    initial begin
        // Reset with all masters requesting, then first grant
        step(4'b1111, 1'b0, 1'b0, 1'b1, "reset0");
        step(4'b1111, 1'b1, 1'b0, 1'b1, "reset1");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "first_grant");
        // Fairness: ack every second cycle
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b0, "fair_ack");
            step(4'b1111, 1'b0, 1'b0, 1'b0, "fair_hold");
        end
        // Hand over to master 2, lock it, then release
        step(4'b0100, 1'b1, 1'b0, 1'b0, "to_m2");
        step(4'b0100, 1'b1, 1'b1, 1'b0, "lock_hold");
        step(4'b0101, 1'b1, 1'b0, 1'b0, "lock_release");
        // Watchdog on master 1
        step(4'b0010, 1'b1, 1'b0, 1'b0, "to_m1");
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b1, 1'b0, "wdog");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "wdog_pulse_end");
        // Ack in the last allowed cycle beats the watchdog
        step(4'b0001, 1'b0, 1'b0, 1'b0, "race_grant");
        for (int i = 0; i < 3; i++) step(4'b0101, 1'b0, 1'b0, 1'b0, "race_wait");
        step(4'b0100, 1'b1, 1'b0, 1'b0, "race_ack");
        // Idle behaviour and stray ack
        step(4'b0000, 1'b1, 1'b0, 1'b0, "to_idle");
        step(4'b0000, 1'b1, 1'b1, 1'b0, "stray_ack");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "idle");
        // Reset mid-transfer together with ack
        step(4'b1010, 1'b0, 1'b0, 1'b0, "pre_rst");
        step(4'b1010, 1'b1, 1'b0, 1'b1, "rst_ack");
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            arb_vector r;
            logic a, l, rs;
            r  = arb_vector'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) r = '0;
            a  = ($urandom_range(0, 9) < 3);
            l  = $urandom_range(0, 1) == 1;
            rs = ($urandom_range(0, 99) == 0);
            step(r, a, l, rs, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
